// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic light command parser: mode encodings,
// ASCII opcodes and the parser FSM state type.
package traffic_light_pkg;

   localparam logic [1:0] MODE_AUTO   = 2'd0;
   localparam logic [1:0] MODE_FLASH  = 2'd1;
   localparam logic [1:0] MODE_ALLRED = 2'd2;
   localparam logic [1:0] MODE_HOLD   = 2'd3;

   localparam logic [7:0] CH_A  = 8'h41;
   localparam logic [7:0] CH_M  = 8'h4D;
   localparam logic [7:0] CH_G  = 8'h47;
   localparam logic [7:0] CH_Y  = 8'h59;
   localparam logic [7:0] CH_P  = 8'h50;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_SP = 8'h20;
   localparam logic [7:0] CH_0  = 8'h30;
   localparam logic [7:0] CH_1  = 8'h31;
   localparam logic [7:0] CH_2  = 8'h32;
   localparam logic [7:0] CH_3  = 8'h33;

   typedef enum logic [1:0] {IDLE, ARG_MODE, ARG_HI, ARG_LO} state_t;

   // Map a mode digit character to {valid, mode}.
   function automatic logic [2:0] digit_to_mode(input logic [7:0] c);
      case (c)
         CH_0:    return {1'b1, MODE_AUTO};
         CH_1:    return {1'b1, MODE_FLASH};
         CH_2:    return {1'b1, MODE_ALLRED};
         CH_3:    return {1'b1, MODE_HOLD};
         default: return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/traffic_light_hex_decode.sv
// ASCII hex digit decoder: '0'-'9', 'A'-'F', 'a'-'f' to a 4-bit nibble.
module traffic_light_hex_decode (
   input  logic [7:0] ascii,
   output logic [3:0] nibble,
   output logic       is_hex
);

   // Letters share low-nibble 1..6 in both cases, so add 9 to get 10..15.
   always_comb begin
      nibble = 4'd0;
      is_hex = 1'b0;
      if (ascii >= 8'h30 && ascii <= 8'h39) begin
         is_hex = 1'b1;
         nibble = ascii[3:0];
      end else if ((ascii >= 8'h41 && ascii <= 8'h46) ||
                   (ascii >= 8'h61 && ascii <= 8'h66)) begin
         is_hex = 1'b1;
         nibble = ascii[3:0] + 4'd9;
      end
   end

endmodule

// File: rtl/traffic_light_cmd_parser.sv
// ASCII command parser between the UART RX stage and the light sequencer.
// Holds mode and phase duration registers; pulses ok/err per command.
module traffic_light_cmd_parser
   import traffic_light_pkg::*;
#(
   parameter int TIME_W         = 8,
   parameter int GREEN_DEFAULT  = 10,
   parameter int YELLOW_DEFAULT = 3,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [1:0]        mode,
   output logic [TIME_W-1:0] green_time,
   output logic [TIME_W-1:0] yellow_time,
   output logic              ped_req,
   output logic              cmd_ok,
   output logic              cmd_err
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            state, nxt_state;
   logic [CNT_W-1:0]  cnt, nxt_cnt;
   logic [3:0]        hi, nxt_hi;
   logic              tgt_yel, nxt_tgt_yel;   // 0: green_time, 1: yellow_time
   logic [1:0]        nxt_mode;
   logic [TIME_W-1:0] nxt_green, nxt_yellow, arg_val;
   logic              nxt_ped, nxt_ok, nxt_err;
   logic [3:0]        nib;
   logic              is_hex;
   logic [2:0]        mdec;

   traffic_light_hex_decode u_hex (
      .ascii  (rx_data),
      .nibble (nib),
      .is_hex (is_hex)
   );

   assign mdec    = digit_to_mode(rx_data);
   assign arg_val = TIME_W'({hi, nib});

   // State and configuration registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         hi          <= 4'd0;
         tgt_yel     <= 1'b0;
         mode        <= MODE_AUTO;
         green_time  <= TIME_W'(GREEN_DEFAULT);
         yellow_time <= TIME_W'(YELLOW_DEFAULT);
         ped_req     <= 1'b0;
         cmd_ok      <= 1'b0;
         cmd_err     <= 1'b0;
      end else begin
         state       <= nxt_state;
         cnt         <= nxt_cnt;
         hi          <= nxt_hi;
         tgt_yel     <= nxt_tgt_yel;
         mode        <= nxt_mode;
         green_time  <= nxt_green;
         yellow_time <= nxt_yellow;
         ped_req     <= nxt_ped;
         cmd_ok      <= nxt_ok;
         cmd_err     <= nxt_err;
      end
   end

   // Parser: byte dispatch per state, inter-byte timeout in argument states.
   always_comb begin
      nxt_state   = state;
      nxt_cnt     = '0;
      nxt_hi      = hi;
      nxt_tgt_yel = tgt_yel;
      nxt_mode    = mode;
      nxt_green   = green_time;
      nxt_yellow  = yellow_time;
      nxt_ped     = 1'b0;
      nxt_ok      = 1'b0;
      nxt_err     = 1'b0;
      if (state == IDLE) begin
         if (rx_valid) begin
            case (rx_data)
               CH_A: begin
                  nxt_mode = MODE_AUTO;
                  nxt_ok   = 1'b1;
               end
               CH_P: begin
                  nxt_ped = 1'b1;
                  nxt_ok  = 1'b1;
               end
               CH_M: nxt_state = ARG_MODE;
               CH_G: begin
                  nxt_state   = ARG_HI;
                  nxt_tgt_yel = 1'b0;
               end
               CH_Y: begin
                  nxt_state   = ARG_HI;
                  nxt_tgt_yel = 1'b1;
               end
               CH_CR, CH_LF, CH_SP: ;
               default: nxt_err = 1'b1;
            endcase
         end
      end else if (rx_valid) begin
         // A byte in the expiry cycle still wins over the timeout.
         nxt_state = IDLE;
         case (state)
            ARG_MODE: begin
               if (mdec[2]) begin
                  nxt_mode = mdec[1:0];
                  nxt_ok   = 1'b1;
               end else begin
                  nxt_err = 1'b1;
               end
            end
            ARG_HI: begin
               if (is_hex) begin
                  nxt_hi    = nib;
                  nxt_state = ARG_LO;
               end else begin
                  nxt_err = 1'b1;
               end
            end
            ARG_LO: begin
               if (is_hex && arg_val != '0) begin
                  if (tgt_yel) nxt_yellow = arg_val;
                  else         nxt_green  = arg_val;
                  nxt_ok = 1'b1;
               end else begin
                  nxt_err = 1'b1;
               end
            end
            default: ;
         endcase
      end else if (cnt == CNT_MAX) begin
         nxt_state = IDLE;
         nxt_err   = 1'b1;
      end else begin
         nxt_cnt = cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_traffic_light_cmd_parser.sv
// Directed bench for the command parser; short timeout to keep runs small.
module tb_traffic_light_cmd_parser;

   localparam int T = 32;

   logic       clk, rst_n, rx_valid;
   logic [7:0] rx_data;
   logic [1:0] mode;
   logic [7:0] green_time, yellow_time;
   logic       ped_req, cmd_ok, cmd_err;
   int         checks = 0;
   int         failures = 0;
   int         n;

   traffic_light_cmd_parser #(
      .TIME_W(8), .GREEN_DEFAULT(10), .YELLOW_DEFAULT(3), .TIMEOUT_CYCLES(T)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .mode(mode), .green_time(green_time), .yellow_time(yellow_time),
      .ped_req(ped_req), .cmd_ok(cmd_ok), .cmd_err(cmd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulses packed as {ped_req, cmd_ok, cmd_err}.
   task automatic chk_p(input string tag, input logic [2:0] exp);
      chk(tag, 32'({ped_req, cmd_ok, cmd_err}), 32'(exp));
   endtask

   task automatic chk_regs(input string tag, input logic [1:0] m,
                           input logic [7:0] g, input logic [7:0] y);
      chk({tag, "_mode"},  32'(mode), 32'(m));
      chk({tag, "_green"}, 32'(green_time), 32'(g));
      chk({tag, "_yel"},   32'(yellow_time), 32'(y));
   endtask

   // Called at a negedge; byte is sampled at the following posedge and the
   // task returns at the negedge where the registered result is visible.
   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   initial begin
      rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (2) @(negedge clk);
      chk_regs("reset", 2'd0, 8'd10, 8'd3);
      chk_p("reset_pulses", 3'b000);
      rst_n = 1'b1;
      @(negedge clk);

      // M 2 then A
      send("M");
      chk_p("m_partial", 3'b000);
      send("2");
      chk_p("m2_pulse", 3'b010);
      chk("m2_mode", 32'(mode), 32'd2);
      @(negedge clk);
      chk_p("m2_one_cycle", 3'b000);
      send("A");
      chk_p("a_pulse", 3'b010);
      chk("a_mode", 32'(mode), 32'd0);

      // Invalid mode digit
      send("M"); send("7");
      chk_p("m7_err", 3'b001);
      chk("m7_mode", 32'(mode), 32'd0);

      // G 1 e
      send("G"); send("1");
      chk("g_partial_green", 32'(green_time), 32'd10);
      send("e");
      chk_p("g1e_pulse", 3'b010);
      chk("g1e_green", 32'(green_time), 32'h1E);

      // Y 0 0 rejected
      send("Y"); send("0"); send("0");
      chk_p("y00_err", 3'b001);
      chk("y00_yel", 32'(yellow_time), 32'd3);

      // Non-hex high digit
      send("Y"); send("x");
      chk_p("yx_err", 3'b001);

      // Y F f -> 0xFF, then restore via Y 0 3
      send("Y"); send("F"); send("f");
      chk("yff_yel", 32'(yellow_time), 32'hFF);
      send("Y"); send("0"); send("3");
      chk("y03_yel", 32'(yellow_time), 32'h03);

      // P
      send("P");
      chk_p("p_pulse", 3'b110);
      @(negedge clk);
      chk_p("p_one_cycle", 3'b000);

      // Unknown opcode, then CR ignored
      send("Z");
      chk_p("z_err", 3'b001);
      chk_regs("z", 2'd0, 8'h1E, 8'h03);
      send(8'h0D);
      chk_p("cr_ignored", 3'b000);

      // Timeout in ARG_LO
      send("G"); send("4");
      n = 0;
      while (!cmd_err && n <= T + 8) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_latency", 32'(n), 32'(T));
      chk("timeout_green", 32'(green_time), 32'h1E);
      send("M"); send("1");
      chk("after_to_mode", 32'(mode), 32'd1);

      // Byte arrives exactly on the expiry cycle
      send("Y"); send("0");
      repeat (T - 1) @(negedge clk);
      chk_p("pre_expiry_quiet", 3'b000);
      send("7");
      chk_p("expiry_byte_wins", 3'b010);
      chk("expiry_yel", 32'(yellow_time), 32'h07);

      // Reset mid-command
      send("G"); send("3");
      rst_n = 1'b0;
      #1;
      chk_regs("midrst", 2'd0, 8'd10, 8'd3);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send("9");
      chk_p("post_rst_9_err", 3'b001);
      chk("post_rst_green", 32'(green_time), 32'd10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
